// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry-to-FT framer.
// frame_word() maps a word index onto the fixed 8-word frame layout.
package telem_pkg;

  localparam int unsigned PKT_W = 88;
  localparam int unsigned FRAME_WORDS = 8;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;

  typedef logic [2:0] word_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [15:0] frame_word(input logic [PKT_W-1:0] pkt,
                                             input logic [15:0]      sync,
                                             input logic [15:0]      seq,
                                             input word_idx_t        idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = sync;
      3'd1:    w = seq;
      3'd2:    w = {8'h00, pkt[87:80]};
      3'd3:    w = pkt[79:64];
      3'd4:    w = pkt[63:48];
      3'd5:    w = pkt[47:32];
      3'd6:    w = pkt[31:16];
      default: w = pkt[15:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/telem_ft_framer_sat_counter.sv
// Width-parameterised counter that increments on inc and sticks at all-ones.
module telem_ft_framer_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/telem_ft_framer.sv
// Frames 88-bit telemetry packets into 8 x 16-bit words (sync, seq, payload) for the
// FT write port; drops packets while streaming is disabled.
module telem_ft_framer
  import telem_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] pkt_data,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic             stream_en,
  output logic [15:0]      ui_din,
  output logic [1:0]       ui_din_be,
  output logic             ui_din_valid,
  input  logic             ui_din_full,
  output logic [15:0]      seq_num,
  output logic [CNT_W-1:0] frames_sent,
  output logic [CNT_W-1:0] drop_count
);

  state_e           state_q, state_d;
  word_idx_t        idx_q, idx_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [15:0]      din_q, din_d;
  logic             valid_q, valid_d;
  logic [15:0]      seq_q, seq_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             in_xfer, out_xfer, drop;

  assign in_xfer  = pkt_valid && pkt_ready;
  assign out_xfer = valid_q && !ui_din_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pkt_q    <= '0;
      din_q    <= '0;
      valid_q  <= 1'b0;
      seq_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pkt_q    <= pkt_d;
      din_q    <= din_d;
      valid_q  <= valid_d;
      seq_q    <= seq_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pkt_d    = pkt_q;
    din_d    = din_q;
    valid_d  = valid_q;
    seq_d    = seq_q;
    frames_d = frames_q;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (stream_en) begin
            pkt_d   = pkt_data;
            din_d   = SYNC_WORD;
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end else begin
            drop = 1'b1;
          end
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (idx_q == word_idx_t'(FRAME_WORDS - 1)) begin
            valid_d  = 1'b0;
            seq_d    = seq_q + 16'd1;
            frames_d = frames_q + CNT_W'(1);
            state_d  = IDLE;
          end else begin
            // Next word is precomputed so ui_din stays a plain register output.
            idx_d = idx_q + 3'd1;
            din_d = frame_word(pkt_q, SYNC_WORD, seq_q, idx_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_ready    = (state_q == IDLE) && !rst;
    ui_din       = din_q;
    ui_din_be    = 2'b11;
    ui_din_valid = valid_q;
    seq_num      = seq_q;
    frames_sent  = frames_q;
  end

  telem_ft_framer_sat_counter #(
    .WIDTH(CNT_W)
  ) u_drop_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (drop),
    .count(drop_count)
  );

endmodule

// File: tb/tb_telem_ft_framer.sv
// Randomised bench for telem_ft_framer against a queue-based frame model.
module tb_telem_ft_framer;
  import telem_pkg::*;

  localparam logic [15:0] SYNC = 16'hA55A;
  localparam logic [87:0] PKT1 = 88'h00_1122_3344_5566_7788_99AA;

  logic        clk = 1'b0;
  logic        rst;
  logic [87:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        stream_en;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full;
  logic [15:0] seq_num;
  logic [31:0] frames_sent;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  telem_ft_framer #(
    .SYNC_WORD(SYNC),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .stream_en   (stream_en),
    .ui_din      (ui_din),
    .ui_din_be   (ui_din_be),
    .ui_din_valid(ui_din_valid),
    .ui_din_full (ui_din_full),
    .seq_num     (seq_num),
    .frames_sent (frames_sent),
    .drop_count  (drop_count)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: words still owed on the wire plus the counters.
  logic [15:0] exp_q[$];
  logic [15:0] m_seq;
  logic [31:0] m_frames;
  logic [31:0] m_drop;
  logic        m_din_zero;
  bit          mon_en;

  function automatic void push_frame(input logic [87:0] p);
    exp_q.push_back(SYNC);
    exp_q.push_back(m_seq);
    exp_q.push_back({8'h00, p[87:80]});
    exp_q.push_back(p[79:64]);
    exp_q.push_back(p[63:48]);
    exp_q.push_back(p[47:32]);
    exp_q.push_back(p[31:16]);
    exp_q.push_back(p[15:0]);
  endfunction

  always @(negedge clk) begin : mon
    bit idle;
    if (mon_en) begin
      idle = (exp_q.size() == 0);
      check_eq("pkt_ready", 64'(pkt_ready), 64'(!rst && idle));
      check_eq("ui_din_valid", 64'(ui_din_valid), 64'(!idle));
      check_eq("ui_din_be", 64'(ui_din_be), 64'(2'b11));
      if (!idle) check_eq("ui_din", 64'(ui_din), 64'(exp_q[0]));
      else if (m_din_zero) check_eq("ui_din_reset", 64'(ui_din), 64'(16'h0000));
      check_eq("seq_num", 64'(seq_num), 64'(m_seq));
      check_eq("frames_sent", 64'(frames_sent), 64'(m_frames));
      check_eq("drop_count", 64'(drop_count), 64'(m_drop));
      // Advance the model to what the coming rising edge will do.
      if (rst) begin
        exp_q.delete();
        m_seq      = '0;
        m_frames   = '0;
        m_drop     = '0;
        m_din_zero = 1'b1;
      end else begin
        if (!idle && !ui_din_full) begin
          if (exp_q.size() == 1) begin
            m_seq++;
            m_frames++;
          end
          void'(exp_q.pop_front());
        end
        if (idle && pkt_valid) begin
          if (stream_en) begin
            push_frame(pkt_data);
            m_din_zero = 1'b0;
          end else if (m_drop != 32'hFFFF_FFFF) begin
            m_drop++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [87:0] d, input logic en);
    bit acc = 1'b0;
    pkt_valid = 1'b1;
    pkt_data  = d;
    stream_en = en;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = pkt_ready;
      tick();
    end
    if (!acc) check_eq("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !ui_din_valid && pkt_ready;
    end
    if (!done) check_eq("idle_timeout", 64'(0), 64'(1));
    tick();
  endtask

  function automatic logic [87:0] rand_pkt();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[87:0];
  endfunction

  initial begin
    rst         = 1'b1;
    pkt_valid   = 1'b0;
    pkt_data    = '0;
    stream_en   = 1'b1;
    ui_din_full = 1'b0;
    m_seq       = '0;
    m_frames    = '0;
    m_drop      = '0;
    m_din_zero  = 1'b1;
    mon_en      = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Single frame, no back-pressure.
    send_pkt(PKT1, 1'b1);
    pkt_valid = 1'b0;
    wait_idle();
    check_eq("seq_after_first", 64'(seq_num), 64'(16'd1));
    check_eq("frames_after_first", 64'(frames_sent), 64'(32'd1));

    // Back-pressure while w2 is presented.
    send_pkt(PKT1, 1'b1);
    pkt_valid = 1'b0;
    tick();
    tick();
    ui_din_full = 1'b1;
    repeat (4) tick();
    ui_din_full = 1'b0;
    wait_idle();
    check_eq("frames_after_stall", 64'(frames_sent), 64'(32'd2));

    // Three packets with pkt_valid held high.
    for (int i = 0; i < 3; i++) send_pkt(rand_pkt(), 1'b1);
    pkt_valid = 1'b0;
    wait_idle();
    check_eq("seq_after_b2b", 64'(seq_num), 64'(16'd5));

    // Drops and saturation.
    for (int i = 0; i < 5; i++) send_pkt(rand_pkt(), 1'b0);
    pkt_valid = 1'b0;
    tick();
    check_eq("drop_five", 64'(drop_count), 64'(32'd5));
    force dut.u_drop_cnt.count_q = 32'hFFFF_FFFE;
    m_drop = 32'hFFFF_FFFE;
    tick();
    release dut.u_drop_cnt.count_q;
    for (int i = 0; i < 3; i++) send_pkt(rand_pkt(), 1'b0);
    pkt_valid = 1'b0;
    tick();
    check_eq("drop_saturated", 64'(drop_count), 64'(32'hFFFF_FFFF));

    // Reset while w4 is on the bus.
    send_pkt(rand_pkt(), 1'b1);
    pkt_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("valid_after_rst", 64'(ui_din_valid), 64'(0));
    check_eq("seq_after_rst", 64'(seq_num), 64'(0));
    send_pkt(PKT1, 1'b1);
    pkt_valid = 1'b0;
    wait_idle();

    // Sequence number wrap.
    force dut.seq_q = 16'hFFFF;
    m_seq = 16'hFFFF;
    tick();
    release dut.seq_q;
    send_pkt(rand_pkt(), 1'b1);
    send_pkt(rand_pkt(), 1'b1);
    pkt_valid = 1'b0;
    wait_idle();
    check_eq("seq_after_wrap", 64'(seq_num), 64'(16'd1));

    // Random traffic, back-pressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      pkt_valid   = ($urandom_range(0, 1) == 1);
      pkt_data    = rand_pkt();
      stream_en   = ($urandom_range(0, 3) != 0);
      ui_din_full = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst         = 1'b0;
    pkt_valid   = 1'b0;
    ui_din_full = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
